// File: rtl/pla_misj_event_capture_if.sv
// ----------------------------------------------------------------------------
// pla_misj_event_capture_if
//   Event drain channel of the misj PLA event capture stage.
//   The master (capture block) presents the FIFO head. The slave (status/trace
//   logic) accepts the head by raising ev_ready.
//
//   ev_valid  master->slave  FIFO non-empty
//   ev_ready  slave->master  consumer accepts the head event
//   ev_data   master->slave  new z value of the head event
//   ev_diff   master->slave  masked changed bits of the head event
//   ev_stamp  master->slave  timestamp of the head event (TS_W bits)
// ----------------------------------------------------------------------------
interface pla_misj_event_capture_if #(
    parameter int TS_W = 16
) ();
    logic            ev_valid;
    logic            ev_ready;
    logic [13:0]     ev_data;
    logic [13:0]     ev_diff;
    logic [TS_W-1:0] ev_stamp;

    modport master (
        output ev_valid,
        output ev_data,
        output ev_diff,
        output ev_stamp,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        input  ev_diff,
        input  ev_stamp,
        output ev_ready
    );
endinterface

// File: rtl/pla_misj_event_capture.sv
// ----------------------------------------------------------------------------
// pla_misj_event_capture
//   Samples the 14-bit misj PLA output vector on z_valid and compares it with
//   a held baseline. Every masked change is pushed as {z, diff, timestamp}
//   into a DEPTH-entry FIFO, which is drained over the ev channel. Pushes that
//   arrive while the FIFO is full are dropped. Drops set a sticky overflow
//   flag and increment a saturating drop counter.
//
//   Ports:
//     clk         clock
//     rst         asynchronous active-high reset
//     z_in        PLA outputs, bit i = z(i)
//     z_valid     sample strobe
//     ovf_clear   clears overflow and drop_cnt (a simultaneous drop wins)
//     ev          event channel (master modport): ev_valid/ev_ready,
//                 ev_data, ev_diff, ev_stamp. These read 0 when the FIFO is empty.
//     fifo_level  FIFO occupancy, 0..DEPTH
//     overflow    sticky, set when an event is dropped
//     drop_cnt    dropped events, saturating
//
//   Optional build macro PLA_MISJ_EVCAP_GLITCH_FILTER_EN:
//     when it is defined, a changed masked value must appear on two
//     consecutive samples before it is compared and baselined.
// ----------------------------------------------------------------------------
module pla_misj_event_capture #(
    parameter int          DEPTH  = 8,
    parameter int          TS_W   = 16,
    parameter logic [13:0] Z_MASK = 14'h0FFF,
    parameter int          DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [13:0]                z_in,
    input  logic                       z_valid,
    input  logic                       ovf_clear,
    pla_misj_event_capture_if.master   ev,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of two in 2..64");
        end
    endgenerate

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t          state;
    logic [13:0]     baseline;
    logic [TS_W-1:0] ts;

    // Compare stage (combinational from the registered baseline and z_in,
    // consumed only by the FIFO write at the sampling edge)
    logic [13:0] diff;
    logic        push_req;
    logic        base_load;

`ifdef PLA_MISJ_EVCAP_GLITCH_FILTER_EN
    logic [13:0] pend_val;
    logic        pend_valid;
    logic        pend_set;
    logic        pend_clr;
    logic [13:0] cur_masked;
`endif

    // FIFO storage and pointers
    logic [13:0]     mem_data  [DEPTH];
    logic [13:0]     mem_diff  [DEPTH];
    logic [TS_W-1:0] mem_stamp [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    // ------------------------------------------------------------------
    // Timestamp: free running and wraps naturally
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Compare
    // ------------------------------------------------------------------
    always_comb begin
        diff      = (z_in ^ baseline) & Z_MASK;
        push_req  = 1'b0;
        base_load = 1'b0;
`ifdef PLA_MISJ_EVCAP_GLITCH_FILTER_EN
        cur_masked = z_in & Z_MASK;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        if (z_valid) begin
            if (state == ST_INIT) begin
                base_load = 1'b1;
                pend_clr  = 1'b1;
            end else if (diff == '0) begin
                // Back to the baseline value. Any pending candidate was a glitch.
                base_load = 1'b1;
                pend_clr  = 1'b1;
            end else if (pend_valid && pend_val == cur_masked) begin
                // Second consecutive sight of the same value confirms it.
                push_req  = 1'b1;
                base_load = 1'b1;
                pend_clr  = 1'b1;
            end else begin
                pend_set  = 1'b1;
            end
        end
`else
        if (z_valid) begin
            base_load = 1'b1;
            push_req  = (state == ST_RUN) && (diff != '0);
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: INIT takes the first sample as the baseline, RUN compares
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            baseline <= '0;
`ifdef PLA_MISJ_EVCAP_GLITCH_FILTER_EN
            pend_val   <= '0;
            pend_valid <= 1'b0;
`endif
        end else begin
            if (base_load) begin
                baseline <= z_in;
            end
            if (z_valid && state == ST_INIT) begin
                state <= ST_RUN;
            end
`ifdef PLA_MISJ_EVCAP_GLITCH_FILTER_EN
            if (pend_set) begin
                pend_val   <= cur_masked;
                pend_valid <= 1'b1;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW + 1)'(DEPTH));
        pop     = !empty && ev.ev_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr]  <= z_in;
            mem_diff[wr_ptr]  <= diff;
            mem_stamp[wr_ptr] <= ts;
        end
    end

    always_comb begin
        ev.ev_valid = !empty;
        if (empty) begin
            ev.ev_data  = '0;
            ev.ev_diff  = '0;
            ev.ev_stamp = '0;
        end else begin
            ev.ev_data  = mem_data[rd_ptr];
            ev.ev_diff  = mem_diff[rd_ptr];
            ev.ev_stamp = mem_stamp[rd_ptr];
        end
        fifo_level = count;
    end

    // ------------------------------------------------------------------
    // Overflow tracking: a drop overrides a coincident clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clear) begin
                drop_cnt <= DROP_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (ovf_clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule
